// File: rtl/ssd_capture.sv
// Receive side of a multiplexed 4-digit seven-segment interface: samples the
// scanned anode/cathode lines, filters glitches and rebuilds coherent frames.
module ssd_capture #(
  parameter int unsigned STABLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] anode,
  input  logic [7:0] cathode,
  input  logic       clr_err,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic [3:0] digit_valid,
  output logic       frame_valid,
  output logic [1:0] err
);

  // Returns {legal, hex value} for an active-low {a..g} pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b0000001: res = 5'h10;
      7'b1001111: res = 5'h11;
      7'b0010010: res = 5'h12;
      7'b0000110: res = 5'h13;
      7'b1001100: res = 5'h14;
      7'b0100100: res = 5'h15;
      7'b0100000: res = 5'h16;
      7'b0001111: res = 5'h17;
      7'b0000000: res = 5'h18;
      7'b0000100: res = 5'h19;
      7'b0001000: res = 5'h1A;
      7'b1100000: res = 5'h1B;
      7'b0110001: res = 5'h1C;
      7'b1000010: res = 5'h1D;
      7'b0110000: res = 5'h1E;
      7'b0111000: res = 5'h1F;
      default:    res = 5'h00;
    endcase
    return res;
  endfunction

  logic [11:0]     in_r;
  logic [7:0]      cnt_r;
  logic            held_r;
  logic [3:0]      seen_r;
  logic [3:0][3:0] shadow_r;
  logic [3:0]      shadow_valid_r;
  logic [3:0][3:0] digits_r;
  logic [3:0]      digit_valid_r;
  logic            frame_valid_r;
  logic [1:0]      err_r;

  logic            same_s;
  logic            capture_s;
  logic            legal_cap_s;
  logic            commit_s;
  logic [1:0]      pos_s;
  logic [3:0]      pos_bit_s;
  logic [4:0]      dec_s;
  logic [3:0]      seen_nxt_s;
  logic [1:0]      err_set_s;

  // Capture/commit decisions from the registered sample and counter state.
  always_comb begin
    same_s      = ({anode, cathode} == in_r);
    capture_s   = (cnt_r == 8'(STABLE_CYCLES)) && !held_r;
    dec_s       = seg_decode(in_r[7:1]);
    commit_s    = (seen_r == 4'b1111);
    legal_cap_s = 1'b0;
    pos_s       = 2'd0;
    case (in_r[11:8])
      4'b1110: begin pos_s = 2'd0; legal_cap_s = capture_s; end
      4'b1101: begin pos_s = 2'd1; legal_cap_s = capture_s; end
      4'b1011: begin pos_s = 2'd2; legal_cap_s = capture_s; end
      4'b0111: begin pos_s = 2'd3; legal_cap_s = capture_s; end
      default: begin pos_s = 2'd0; legal_cap_s = 1'b0; end
    endcase
    pos_bit_s    = 4'b0001 << pos_s;
    err_set_s[1] = capture_s && !legal_cap_s && (in_r[11:8] != 4'b1111);
    err_set_s[0] = legal_cap_s && !dec_s[4];
    // A commit clears seen before this edge's capture is merged in.
    if (commit_s) begin
      seen_nxt_s = 4'b0000;
    end else begin
      seen_nxt_s = seen_r;
    end
    if (legal_cap_s) begin
      seen_nxt_s = seen_nxt_s | pos_bit_s;
    end else begin
      seen_nxt_s = seen_nxt_s;
    end
  end

  // Input register and saturating stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_r   <= 12'h000;
      cnt_r  <= 8'd0;
      held_r <= 1'b0;
    end else begin
      in_r   <= {anode, cathode};
      held_r <= same_s && (cnt_r == 8'd255);
      if (!same_s) begin
        cnt_r <= 8'd1;
      end else if (cnt_r != 8'd255) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Shadow frame assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r       <= '0;
      shadow_valid_r <= 4'b0000;
      seen_r         <= 4'b0000;
    end else begin
      seen_r <= seen_nxt_s;
      if (legal_cap_s) begin
        shadow_r[pos_s]       <= dec_s[4] ? dec_s[3:0] : 4'h0;
        shadow_valid_r[pos_s] <= dec_s[4];
      end
    end
  end

  // Frame commit and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_r      <= '0;
      digit_valid_r <= 4'b0000;
      frame_valid_r <= 1'b0;
      err_r         <= 2'b00;
    end else begin
      frame_valid_r <= commit_s;
      if (commit_s) begin
        digits_r      <= shadow_r;
        digit_valid_r <= shadow_valid_r;
      end
      err_r <= (clr_err ? 2'b00 : err_r) | err_set_s;
    end
  end

  assign ones        = digits_r[0];
  assign tens        = digits_r[1];
  assign hundreds    = digits_r[2];
  assign thousands   = digits_r[3];
  assign digit_valid = digit_valid_r;
  assign frame_valid = frame_valid_r;
  assign err         = err_r;

endmodule

// File: tb/tb_ssd_capture.sv
// Bench for ssd_capture: two instances (STABLE_CYCLES 1 and 3) share one
// stimulus stream and are compared every cycle against a run-length model.
module tb_ssd_capture;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      anode = 4'hF;
  logic [7:0]      cathode = 8'hFF;
  logic            clr_err = 1'b0;
  logic [1:0][3:0] ones_w, tens_w, hund_w, thou_w, dv_w;
  logic [1:0]      fv_w;
  logic [1:0][1:0] err_w;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  always #5 clk = ~clk;

  ssd_capture #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .anode(anode), .cathode(cathode), .clr_err(clr_err),
    .ones(ones_w[0]), .tens(tens_w[0]), .hundreds(hund_w[0]), .thousands(thou_w[0]),
    .digit_valid(dv_w[0]), .frame_valid(fv_w[0]), .err(err_w[0]));

  ssd_capture #(.STABLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .anode(anode), .cathode(cathode), .clr_err(clr_err),
    .ones(ones_w[1]), .tens(tens_w[1]), .hundreds(hund_w[1]), .thousands(thou_w[1]),
    .digit_valid(dv_w[1]), .frame_valid(fv_w[1]), .err(err_w[1]));

  // Reference model: each sample's run length decides capture; frames are
  // published from a shadow copy once all four positions have been seen.
  int         st [2] = '{1, 3};
  logic [11:0] m_reg [2];
  int         m_run [2];
  logic [3:0] m_seen [2];
  logic [3:0] m_shv [2];
  logic [3:0] m_dv [2];
  logic [3:0] m_sh [2][4];
  logic [3:0] m_dig [2][4];
  logic       m_fv [2];
  logic [1:0] m_err [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_reg[i] = 12'h000; m_run[i] = 0; m_seen[i] = 4'h0; m_shv[i] = 4'h0;
      m_dv[i] = 4'h0; m_fv[i] = 1'b0; m_err[i] = 2'b00;
      for (int k = 0; k < 4; k++) begin m_sh[i][k] = 4'h0; m_dig[i][k] = 4'h0; end
    end
  endtask

  task automatic model_edge(input int i);
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] eset;
    logic [3:0] val;
    bit found;
    int pos;
    an = m_reg[i][11:8];
    seg = m_reg[i][7:1];
    eset = 2'b00;
    pos = -1;
    m_fv[i] = 1'b0;
    if (m_seen[i] == 4'hF) begin
      for (int k = 0; k < 4; k++) m_dig[i][k] = m_sh[i][k];
      m_dv[i] = m_shv[i];
      m_fv[i] = 1'b1;
      m_seen[i] = 4'h0;
    end
    if (m_run[i] == st[i]) begin
      for (int p = 0; p < 4; p++) if (an == ~(4'b0001 << p)) pos = p;
      if (pos >= 0) begin
        found = 1'b0;
        val = 4'h0;
        for (int v = 0; v < 16; v++) if (SEG[v] == seg) begin found = 1'b1; val = v[3:0]; end
        m_sh[i][pos] = found ? val : 4'h0;
        m_shv[i][pos] = found;
        if (!found) eset[0] = 1'b1;
        m_seen[i][pos] = 1'b1;
      end else if (an != 4'hF) begin
        eset[1] = 1'b1;
      end
    end
    m_err[i] = (clr_err ? 2'b00 : m_err[i]) | eset;
    if ({anode, cathode} == m_reg[i]) m_run[i]++;
    else begin m_reg[i] = {anode, cathode}; m_run[i] = 1; end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int i);
    chk($sformatf("digits%0d", i), {thou_w[i], hund_w[i], tens_w[i], ones_w[i]},
        {m_dig[i][3], m_dig[i][2], m_dig[i][1], m_dig[i][0]});
    chk($sformatf("digit_valid%0d", i), {12'h000, dv_w[i]}, {12'h000, m_dv[i]});
    chk($sformatf("frame_valid%0d", i), {15'h0000, fv_w[i]}, {15'h0000, m_fv[i]});
    chk($sformatf("err%0d", i), {14'h0000, err_w[i]}, {14'h0000, m_err[i]});
  endtask

  task automatic cycle(input logic [3:0] a, input logic [7:0] c, input logic clr);
    anode = a; cathode = c; clr_err = clr;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_all(0);
    check_all(1);
  endtask

  // One scan pass; bad_pos gets an undecodable all-off cathode.
  task automatic scan(input logic [15:0] val, input int hold, input int gap, input int bad_pos);
    logic [3:0] d;
    logic [7:0] c;
    for (int p = 0; p < 4; p++) begin
      d = val[p*4 +: 4];
      c = (p == bad_pos) ? 8'hFF : {SEG[d], 1'b1};
      repeat (hold) cycle(~(4'b0001 << p), c, 1'b0);
      repeat (gap) cycle(4'hF, 8'hFF, 1'b0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
    #1 check_all(0);
    check_all(1);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    logic [3:0] ra;
    logic [7:0] rc;
    int hold, gap, bad;
    model_reset();
    repeat (3) @(negedge clk);
    check_all(0);
    check_all(1);
    rst = 1'b0;

    repeat (4) scan(16'h1234, 1, 0, -1);
    repeat (3) scan(16'hBEEF, 1, 0, -1);
    cycle(4'b1110, {SEG[4'hF], 1'b1}, 1'b0);
    cycle(4'b1101, {SEG[4'hE], 1'b1}, 1'b0);
    cycle(4'b1011, {SEG[4'h0], 1'b1}, 1'b0);
    cycle(4'b0111, {SEG[4'hA], 1'b1}, 1'b0);
    repeat (3) scan(16'hA0C5, 1, 0, -1);

    repeat (3) scan(16'h5678, 2, 0, -1);
    repeat (3) scan(16'h9ABC, 3, 0, -1);

    repeat (2) scan(16'h4321, 1, 0, 1);
    repeat (2) scan(16'h4321, 3, 0, 1);
    cycle(4'hF, 8'hFF, 1'b1);
    cycle(4'hF, 8'hFF, 1'b0);

    scan(16'h1357, 3, 1, -1);
    repeat (3) cycle(4'b1100, {SEG[4'h8], 1'b1}, 1'b0);
    repeat (2) scan(16'h2468, 3, 2, -1);
    cycle(4'hF, 8'hFF, 1'b1);

    scan(16'hDEAD, 3, 0, -1);
    cycle(4'b1110, {SEG[4'h7], 1'b1}, 1'b0);
    cycle(4'b1110, {SEG[4'h7], 1'b1}, 1'b0);
    cycle(4'b1110, {SEG[4'h7], 1'b1}, 1'b0);
    cycle(4'b1101, {SEG[4'h6], 1'b1}, 1'b0);
    cycle(4'b1101, {SEG[4'h6], 1'b1}, 1'b0);
    cycle(4'b1101, {SEG[4'h6], 1'b1}, 1'b0);
    pulse_reset();
    cycle(4'b1011, {SEG[4'h5], 1'b1}, 1'b0);
    cycle(4'b0111, {SEG[4'h4], 1'b1}, 1'b0);
    repeat (2) scan(16'hF00D, 3, 0, -1);

    for (int f = 0; f < 80; f++) begin
      v = 16'($urandom);
      hold = $urandom_range(1, 4);
      gap = $urandom_range(0, 1);
      bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
      scan(v, hold, gap, bad);
      if ($urandom_range(0, 5) == 0) begin
        ra = 4'($urandom);
        rc = 8'($urandom);
        cycle(ra, rc, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 7) == 0) cycle(4'hF, 8'hFF, 1'b1);
      if (f == 40) pulse_reset();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/ssd_capture.md
Name: ssd_capture

Overview:
- Receive side of the multiplexed 4-digit seven-segment interface: samples active-low anode[3:0]/cathode[7:0] from a scanning display driver and rebuilds the four hex digits.
- Used as a loopback checker on the board and in benches: captures each scanned position, filters glitches, decodes segment patterns to hex, and publishes a complete, coherent 4-digit frame with a one-cycle strobe.

Parameters:
- STABLE_CYCLES, 1, consecutive identical samples needed before a position is captured (legal 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- anode  input  4  active-low digit select; bit0 = ones, bit3 = thousands.
- cathode  input  8  active-low segments; [7:1] = {a,b,c,d,e,f,g}, [0] = dp (ignored).
- clr_err  input  1  synchronous clear of the sticky error flags.
- ones, tens, hundreds, thousands  output  4 each  last committed digit values.
- digit_valid  output  4  per position: committed pattern decoded legally (bit0 = ones).
- frame_valid  output  1  one-cycle pulse when a new frame is committed.
- err  output  2  sticky flags: [0] undecodable segment pattern, [1] illegal anode (more than one bit low).

Behaviour:
- Reset values: all digit outputs 0, digit_valid 0000, frame_valid 0, err 00. Reset also clears the input register, stability counter, seen-mask and shadow registers.
- Stage 1: {anode, cathode} registered every clock into in_reg.
- Stability counter (8-bit, saturating at 255):
  - Loads 1 when in_reg changes from its previous value.
  - Increments otherwise.
  - Capture event fires only on the cycle the counter equals STABLE_CYCLES. A held pattern is never re-captured.
- Anode classification at capture:
  - Exactly one bit low: legal position.
  - 1111: idle; no capture, no error.
  - Anything else: no capture, set err[1].
- Segment decode, {a..g} active-low:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6
  - 0001111→7, 0000000→8, 0000100→9, 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F
- Any other segment pattern: shadow value = 0, shadow valid bit = 0, set err[0]. The position still counts as seen.
- Legal capture: shadow[pos] ← decoded value, shadow_valid[pos] ← 1, seen[pos] ← 1. Recapturing an already-seen position overwrites its shadow entry.
- Commit: on the edge after seen becomes 1111, copy shadow → output registers and shadow_valid → digit_valid, pulse frame_valid high for exactly one cycle, clear seen.
- Capture and commit on the same edge: the commit uses the prior shadow contents. seen becomes only the newly captured bit.
- Latency with STABLE_CYCLES=1: the 4th digit presented at the pins before edge k is registered at k, captured at k+1, and committed with frame_valid high after k+2.
- Outputs hold between commits. There is no timeout: a missing position stalls commit indefinitely.
- err bits set and clear:
  - Bits are sticky.
  - clr_err clears them at the next edge.
  - A set event on that same edge wins.
- rst asserted mid-frame: immediate return to reset values. The partial frame is discarded.

Test Plan:
- Driver scanning 1234 (anode 1110/1101/1011/0111, one cycle each, STABLE_CYCLES=1) → frame_valid pulses every 4 cycles; ones=4, tens=3, hundreds=2, thousands=1; digit_valid=1111; err=00.
- Hex frame BEEF, then A0C5 swapped in mid-scan → next frame is a mix of old and new positions as scanned; the frame after that reads A0C5 exactly. Outputs never change without frame_valid.
- STABLE_CYCLES=3, each digit held 2 cycles → no frame_valid, outputs stay 0. With each digit held 3 cycles → frames commit correctly.
- Cathode 1111111 on the tens slot → frame commits with digit_valid=1101, tens=0, err=01. Pulsing clr_err → err=00.
- Anode 1100 injected once → no capture, err[1]=1. Anode 1111 gaps between digits → ignored, err unchanged.
- rst asserted after 2 digits captured → all outputs 0. After release, a full scan is needed before the first frame_valid.
